// File: rtl/decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decoder_pkg
//  Description : Shared enable code, encoder state type and priority helper
//                for the key encoder / LED decoder pair.
//  Revision    : 1.0  initial release
// ============================================================================
package decoder_pkg;

    localparam logic [2:0] ENABLE_ACTIVE = 3'b100;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } enc_state_t;

    // Index of the highest low bit; returns 0 when no bit is low.
    function automatic logic [2:0] highest_low(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchroniser plus whole-vector debouncer; the output
//                only follows a key vector that held still for DB_CYCLES.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
    import decoder_pkg::*;
#(
    parameter int W         = 8,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw_n,
    output logic [W-1:0] stable_n
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [W-1:0]     r_sync1;
    logic [W-1:0]     r_sync2;
    logic [W-1:0]     r_cand;
    logic [W-1:0]     r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_cand   <= '1;
            r_stable <= '1;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw_n;
            r_sync2 <= r_sync1;
            // Any change restarts the count; the counter parks once it expires.
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_stable <= r_cand;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign stable_n = r_stable;

endmodule
`default_nettype wire

// File: rtl/encoder_83.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_83
//  Description : Debounced 8-to-3 priority encoder for active-low keys with
//                valid flag and one-cycle key_event strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module encoder_83
    import decoder_pkg::*;
#(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] enable,
    input  logic [7:0] key_n,
    output logic [2:0] code,
    output logic       valid,
    output logic       key_event
);

    logic [7:0] w_stable_n;
    logic       w_none;
    logic [2:0] w_pri;
    logic       w_enabled;

    enc_state_t r_state;
    enc_state_t w_state_nxt;
    logic [2:0] r_code;
    logic       r_valid;
    logic       r_key_event;
    logic [2:0] w_code_nxt;
    logic       w_valid_nxt;
    logic       w_event_nxt;

    key_debounce #(
        .W         (8),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .raw_n    (key_n),
        .stable_n (w_stable_n)
    );

    assign w_none    = (w_stable_n == 8'hFF);
    assign w_pri     = highest_low(w_stable_n);
    assign w_enabled = (enable == ENABLE_ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_valid     <= 1'b0;
            r_key_event <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_valid     <= w_valid_nxt;
            r_key_event <= w_event_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!w_enabled) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (!w_none) w_state_nxt = PRESSED;
                PRESSED: if (w_none)  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Release is silent; only a new or changed priority raises key_event.
    always_comb begin
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        w_event_nxt = 1'b0;
        if (!w_enabled) begin
            w_code_nxt  = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_none) begin
                        w_code_nxt  = w_pri;
                        w_valid_nxt = 1'b1;
                        w_event_nxt = 1'b1;
                    end
                end
                PRESSED: begin
                    if (w_none) begin
                        w_code_nxt  = '0;
                        w_valid_nxt = 1'b0;
                    end else if (w_pri != r_code) begin
                        w_code_nxt  = w_pri;
                        w_event_nxt = 1'b1;
                    end
                end
                default: begin
                    w_code_nxt  = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    assign code      = r_code;
    assign valid     = r_valid;
    assign key_event = r_key_event;

endmodule
`default_nettype wire

// File: tb/tb_encoder_83.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encoder_83
//  Description : Self-checking bench for encoder_83 with a cycle model feeding
//                a scoreboard queue plus directed latency/event checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encoder_83;

    localparam int C_DB  = 4;
    localparam int C_LAT = 2 + C_DB + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] enable;
    logic [7:0] key_n;
    logic [2:0] code;
    logic       valid;
    logic       key_event;

    int n_chk = 0;
    int n_err = 0;
    bit sb_on = 1'b1;

    encoder_83 #(
        .DB_CYCLES (C_DB),
        .CNT_W     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .key_n     (key_n),
        .code      (code),
        .valid     (valid),
        .key_event (key_event)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model of the encoder; its expected outputs go to the scoreboard.
    logic [7:0] m_s1, m_s2, m_cand, m_stable;
    int         m_cnt;
    bit         m_pressed;
    logic [2:0] m_code, m_pri;
    logic       m_valid, m_evt;
    logic [4:0] sb[$];

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = 8'hFF; m_s2 = 8'hFF; m_cand = 8'hFF; m_stable = 8'hFF;
            m_cnt = 0; m_pressed = 1'b0;
            m_code = '0; m_valid = 1'b0; m_evt = 1'b0;
        end else begin
            m_pri = 3'd0;
            for (int i = 7; i >= 0; i--) begin
                if (!m_stable[i]) begin
                    m_pri = 3'(i);
                    break;
                end
            end
            if (enable != 3'b100) begin
                m_pressed = 1'b0; m_code = '0; m_valid = 1'b0; m_evt = 1'b0;
            end else if (!m_pressed) begin
                m_evt = 1'b0;
                if (m_stable != 8'hFF) begin
                    m_pressed = 1'b1; m_code = m_pri; m_valid = 1'b1; m_evt = 1'b1;
                end
            end else if (m_stable == 8'hFF) begin
                m_pressed = 1'b0; m_code = '0; m_valid = 1'b0; m_evt = 1'b0;
            end else if (m_pri != m_code) begin
                m_code = m_pri; m_evt = 1'b1;
            end else begin
                m_evt = 1'b0;
            end
            if (m_s2 != m_cand) begin
                m_cand = m_s2; m_cnt = 0;
            end else if (m_cnt == C_DB - 1) begin
                m_stable = m_cand;
            end else begin
                m_cnt++;
            end
            m_s2 = m_s1;
            m_s1 = key_n;
        end
        sb.push_back({m_code, m_valid, m_evt});
    end

    always @(negedge clk) begin
        logic [4:0] exp_v;
        if (sb_on && sb.size() > 0) begin
            exp_v = sb.pop_front();
            check("sb_out", {27'd0, code, valid, key_event}, {27'd0, exp_v});
        end
    end

    task automatic run_window(input int n, output int first_k, output int n_ev);
        first_k = -1;
        n_ev    = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (key_event) begin
                n_ev++;
                if (first_k < 0) first_k = k;
            end
        end
    endtask

    initial begin
        int fk;
        int ne;
        int bad;

        // Reset with every key low: outputs must stay clear throughout.
        rst = 1'b1; enable = 3'b100; key_n = 8'h00;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("rst_out", {29'd0, code, valid, key_event}, 32'd0);
        end
        key_n = 8'hFF;
        @(negedge clk);
        rst = 1'b0;
        run_window(12, fk, ne);
        check("idle_events", ne, 0);
        check("idle_valid", valid, 0);

        // Single press; key_n is sampled at the first edge, event C_LAT edges later.
        key_n = 8'b1111_0111;
        run_window(15, fk, ne);
        check("press_first", fk, C_LAT + 1);
        check("press_events", ne, 1);
        check("press_code", code, 3);
        check("press_valid", valid, 1);

        // Priority rises to key 7, then falls back to key 0 without release.
        key_n = 8'b0111_1110;
        run_window(15, fk, ne);
        check("pri7_first", fk, C_LAT + 1);
        check("pri7_events", ne, 1);
        check("pri7_code", code, 7);
        key_n = 8'hFE;
        run_window(15, fk, ne);
        check("pri0_events", ne, 1);
        check("pri0_code", code, 0);
        check("pri0_valid", valid, 1);

        // Release, then bounce key 2 faster than the debounce window.
        key_n = 8'hFF;
        run_window(15, fk, ne);
        check("release_events", ne, 0);
        check("release_valid", valid, 0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) key_n[2] = ~key_n[2];
            @(negedge clk);
            if (valid || key_event) bad++;
        end
        key_n = 8'hFF;
        run_window(15, fk, ne);
        check("bounce_quiet", bad, 0);
        check("bounce_events", ne, 0);
        check("bounce_valid", valid, 0);

        // Enable drop and restore with key 5 held.
        key_n = 8'b1101_1111;
        run_window(15, fk, ne);
        check("k5_valid", valid, 1);
        check("k5_code", code, 5);
        enable = 3'b101;
        @(negedge clk);
        check("dis_valid", valid, 0);
        check("dis_code", code, 0);
        enable = 3'b100;
        @(negedge clk);
        check("reen_valid", valid, 1);
        check("reen_code", code, 5);
        check("reen_event", key_event, 1);
        @(negedge clk);
        check("reen_event_once", key_event, 0);

        // Reset mid-press discards all debounce progress.
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out", {29'd0, code, valid, key_event}, 32'd0);
        rst = 1'b0;
        run_window(15, fk, ne);
        check("postrst_first", fk, C_LAT + 1);
        check("postrst_events", ne, 1);
        check("postrst_code", code, 5);
        check("postrst_valid", valid, 1);

        sb_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
